mem_ctrl: RTL



---
 rtl/mem_ctrl_if.sv | 44 ++++
 rtl/mem_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// Request, response and byte-wide RAM bus signals of the memory controller.
// The controller uses the slave view; the surrounding pipeline/RAM use the master view.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_require_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  flush_i;
  logic                  if_busy_o;
  logic                  if_enable_o;
  logic [31:0]           if_data_o;

  logic                  mem_require_i;
  logic                  mem_wr_i;
  logic [ADDR_WIDTH-1:0] mem_addr_i;
  logic [2:0]            mem_length_i;
  logic [31:0]           mem_data_i;
  logic                  mem_busy_o;
  logic                  mem_enable_o;
  logic [31:0]           mem_data_o;

  logic [7:0]            ram_din_i;
  logic [7:0]            ram_dout_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic                  ram_wr_o;

  modport master (
    output if_require_i, if_addr_i, flush_i,
    output mem_require_i, mem_wr_i, mem_addr_i, mem_length_i, mem_data_i,
    output ram_din_i,
    input  if_busy_o, if_enable_o, if_data_o,
    input  mem_busy_o, mem_enable_o, mem_data_o,
    input  ram_dout_o, ram_addr_o, ram_wr_o
  );

  modport slave (
    input  if_require_i, if_addr_i, flush_i,
    input  mem_require_i, mem_wr_i, mem_addr_i, mem_length_i, mem_data_i,
    input  ram_din_i,
    output if_busy_o, if_enable_o, if_data_o,
    output mem_busy_o, mem_enable_o, mem_data_o,
    output ram_dout_o, ram_addr_o, ram_wr_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates IF and MEM requests onto a byte-wide RAM, serialising 1/2/4-byte
// accesses and assembling read bytes little-endian.
module mem_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter bit MEM_PRIORITY = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                state_q, state_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [2:0]            len_q, len_n;
  logic [2:0]            cnt_q, cnt_n;
  logic [31:0]           wdata_q, wdata_n;
  logic [31:0]           rdata_q, rdata_n;
  logic                  owner_mem_q, owner_mem_n;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_n;
  logic [7:0]            ram_dout_q, ram_dout_n;
  logic                  ram_wr_q, ram_wr_n;
  logic                  if_en_q, if_en_n;
  logic                  mem_en_q, mem_en_n;
  logic [31:0]           if_data_q, if_data_n;
  logic [31:0]           mem_data_q, mem_data_n;

  logic                  if_go, mem_go, pick_mem;
  logic [2:0]            mem_len_norm;
  logic [31:0]           rdata_cap;
  logic [4:0]            rd_sel, wr_sel;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  more_bytes;

  // cnt_q counts edges spent in READ/WRITE; read byte k lands when cnt_q == k+1
  always_comb begin
    if_go        = bus.if_require_i && !bus.flush_i;
    mem_go       = bus.mem_require_i;
    pick_mem     = MEM_PRIORITY ? mem_go : (mem_go && !if_go);
    unique case (bus.mem_length_i)
      3'b001:  mem_len_norm = 3'd1;
      3'b010:  mem_len_norm = 3'd2;
      default: mem_len_norm = 3'd4;
    endcase
    rd_sel             = {cnt_q[1:0] - 2'd1, 3'b000};
    wr_sel             = {cnt_q[1:0] + 2'd1, 3'b000};
    rdata_cap          = rdata_q;
    rdata_cap[rd_sel +: 8] = bus.ram_din_i;
    next_addr          = addr_q + ADDR_WIDTH'(cnt_q + 3'd1);
    more_bytes         = (cnt_q + 3'd1) < len_q;
  end

  always_comb begin
    state_n     = state_q;
    addr_n      = addr_q;
    len_n       = len_q;
    cnt_n       = cnt_q;
    wdata_n     = wdata_q;
    rdata_n     = rdata_q;
    owner_mem_n = owner_mem_q;
    ram_addr_n  = ram_addr_q;
    ram_dout_n  = ram_dout_q;
    ram_wr_n    = 1'b0;
    if_en_n     = 1'b0;
    mem_en_n    = 1'b0;
    if_data_n   = if_data_q;
    mem_data_n  = mem_data_q;

    unique case (state_q)
      IDLE: begin
        if (pick_mem) begin
          state_n     = bus.mem_wr_i ? WRITE : READ;
          addr_n      = bus.mem_addr_i;
          len_n       = mem_len_norm;
          cnt_n       = 3'd0;
          wdata_n     = bus.mem_data_i;
          rdata_n     = 32'd0;
          owner_mem_n = 1'b1;
          ram_addr_n  = bus.mem_addr_i;
          ram_wr_n    = bus.mem_wr_i;
          if (bus.mem_wr_i) ram_dout_n = bus.mem_data_i[7:0];
        end else if (if_go) begin
          state_n     = READ;
          addr_n      = bus.if_addr_i;
          len_n       = 3'd4;
          cnt_n       = 3'd0;
          rdata_n     = 32'd0;
          owner_mem_n = 1'b0;
          ram_addr_n  = bus.if_addr_i;
        end
      end
      READ: begin
        if (!owner_mem_q && bus.flush_i) begin
          state_n = IDLE;
        end else begin
          if (cnt_q != 3'd0) rdata_n = rdata_cap;
          if (more_bytes) ram_addr_n = next_addr;
          if (cnt_q == len_q) begin
            state_n = IDLE;
            if (owner_mem_q) begin
              mem_en_n   = 1'b1;
              mem_data_n = rdata_cap;
            end else begin
              if_en_n   = 1'b1;
              if_data_n = rdata_cap;
            end
          end else begin
            cnt_n = cnt_q + 3'd1;
          end
        end
      end
      WRITE: begin
        if (more_bytes) begin
          ram_wr_n   = 1'b1;
          ram_addr_n = next_addr;
          ram_dout_n = wdata_q[wr_sel +: 8];
          cnt_n      = cnt_q + 3'd1;
        end else begin
          state_n  = IDLE;
          mem_en_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= 3'd0;
      cnt_q       <= 3'd0;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
      owner_mem_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      if_en_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      if_data_q   <= 32'd0;
      mem_data_q  <= 32'd0;
    end else begin
      state_q     <= state_n;
      addr_q      <= addr_n;
      len_q       <= len_n;
      cnt_q       <= cnt_n;
      wdata_q     <= wdata_n;
      rdata_q     <= rdata_n;
      owner_mem_q <= owner_mem_n;
      ram_addr_q  <= ram_addr_n;
      ram_dout_q  <= ram_dout_n;
      ram_wr_q    <= ram_wr_n;
      if_en_q     <= if_en_n;
      mem_en_q    <= mem_en_n;
      if_data_q   <= if_data_n;
      mem_data_q  <= mem_data_n;
    end
  end

  assign bus.if_busy_o    = (state_q != IDLE);
  assign bus.mem_busy_o   = (state_q != IDLE);
  assign bus.if_enable_o  = if_en_q;
  assign bus.if_data_o    = if_data_q;
  assign bus.mem_enable_o = mem_en_q;
  assign bus.mem_data_o   = mem_data_q;
  assign bus.ram_addr_o   = ram_addr_q;
  assign bus.ram_dout_o   = ram_dout_q;
  assign bus.ram_wr_o     = ram_wr_q;

endmodule
